// File: rtl/tile_result_writer.sv
// -----------------------------------------------------------------------------
// tile_result_writer
//
// Purpose:
//   Collects the four elements of each 2x2 result tile from the multiplier
//   core, turns each into a {byte address, data} write beat for a row-major
//   result matrix, queues the beats in a small FIFO and presents them one at a
//   time on a simple request/grant write port.  The tile position (row, column)
//   advances every time a C22 element is seen, so the core only has to strobe
//   elements in tile order.
//
// Parameters:
//   DEPTH  FIFO entry count (power of two, >= 4)
//   AW     memory address width
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse: load base_addr/n_cols, clear tile counters
//                and sticky flags (FIFO contents are kept)
//   base_addr    byte address of result element (0,0), sampled on start
//   n_cols       result matrix width in elements (even, >= 2), sampled on start
//   c11ready..c22ready  per-element capture strobes
//   C11..C22     signed 32-bit tile result values
//   mem_req      write request valid (FIFO non-empty)
//   mem_gnt      write accepted when high together with mem_req
//   mem_addr     write byte address (head entry, 0 when idle)
//   mem_wdata    write data (head entry, 0 when idle)
//   mem_we       constant 1
//   mem_be       constant 4'hF
//   busy         same as mem_req
//   overflow     sticky: a strobed value was dropped because the FIFO was full
//   proto_err    sticky: more than one strobe was high in a cycle
//   tiles_done   number of tiles whose C22 was seen since start (wraps)
//
// Handshake: mem_req/mem_gnt follow valid/ready rules.  Once mem_req is high,
// mem_req, mem_addr and mem_wdata stay constant until a cycle in which mem_gnt
// is also high; the beat transfers on that rising edge and the next head entry
// (if any) is presented in the following cycle.  mem_gnt may depend on
// mem_req; mem_req never depends on mem_gnt.
// -----------------------------------------------------------------------------
module tile_result_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic [15:0]        n_cols,
  input  logic               c11ready,
  input  logic               c12ready,
  input  logic               c21ready,
  input  logic               c22ready,
  input  logic signed [31:0] C11,
  input  logic signed [31:0] C12,
  input  logic signed [31:0] C21,
  input  logic signed [31:0] C22,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [AW-1:0]      mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic               busy,
  output logic               overflow,
  output logic               proto_err,
  output logic [15:0]        tiles_done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [AW-1:0] r_base;
  logic [15:0]   r_ncols;
  logic [15:0]   r_tr;
  logic [15:0]   r_tc;
  logic [15:0]   r_tiles_done;
  logic          r_overflow;
  logic          r_proto_err;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [AW-1:0] r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];

  // ---------------------------------------------------------------------------
  // Strobe selection
  // ---------------------------------------------------------------------------
  logic [3:0]  w_strobes;
  logic        w_multi;
  logic        w_sel_valid;
  logic        w_sel_i;
  logic        w_sel_j;
  logic [31:0] w_sel_data;
  logic        w_c22_sel;

  assign w_strobes = {c11ready, c12ready, c21ready, c22ready};
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi   = (w_strobes & (w_strobes - 4'd1)) != 4'd0;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_i     = 1'b0;
    w_sel_j     = 1'b0;
    w_sel_data  = 32'd0;
    if (c11ready) begin
      w_sel_valid = 1'b1;
      w_sel_data  = C11;
    end else if (c12ready) begin
      w_sel_valid = 1'b1;
      w_sel_j     = 1'b1;
      w_sel_data  = C12;
    end else if (c21ready) begin
      w_sel_valid = 1'b1;
      w_sel_i     = 1'b1;
      w_sel_data  = C21;
    end else if (c22ready) begin
      w_sel_valid = 1'b1;
      w_sel_i     = 1'b1;
      w_sel_j     = 1'b1;
      w_sel_data  = C22;
    end
  end

  // Only a C22 that actually wins selection closes the tile.
  assign w_c22_sel = w_sel_valid & w_sel_i & w_sel_j;

  // ---------------------------------------------------------------------------
  // Effective configuration and tile position for this cycle.  A strobe in
  // the same cycle as start must already see the new base/width and the tile
  // origin, so start bypasses the registers here.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_base_eff;
  logic [15:0]   w_ncols_eff;
  logic [15:0]   w_tr_eff;
  logic [15:0]   w_tc_eff;

  assign w_base_eff  = start ? base_addr : r_base;
  assign w_ncols_eff = start ? n_cols    : r_ncols;
  assign w_tr_eff    = start ? 16'd0     : r_tr;
  assign w_tc_eff    = start ? 16'd0     : r_tc;

  // ---------------------------------------------------------------------------
  // Address: base + (((2*tr + i) * ncols + 2*tc + j) << 2), all modulo 2^AW.
  // Every term is reduced to AW bits before use; truncating operands of
  // add/multiply does not change the result modulo 2^AW.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_elem;
  logic [AW-1:0] w_addr;

  assign w_row  = AW'({w_tr_eff, w_sel_i});
  assign w_col  = AW'({w_tc_eff, w_sel_j});
  assign w_elem = (w_row * AW'(w_ncols_eff)) + w_col;
  assign w_addr = w_base_eff + (w_elem << 2);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  assign w_wr_idx = r_wptr[PW-1:0];
  assign w_rd_idx = r_rptr[PW-1:0];
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (w_wr_idx == w_rd_idx);
  assign w_pop    = !w_empty && mem_gnt;
  // A full FIFO that is popping this edge frees a slot for the push.
  assign w_push   = w_sel_valid && (!w_full || w_pop);
  assign w_drop   = w_sel_valid && w_full && !w_pop;

  // ---------------------------------------------------------------------------
  // Next tile position, tile count and sticky flags.  Start clears first, then
  // any same-cycle event is applied on top of the cleared values.
  // ---------------------------------------------------------------------------
  logic [15:0] w_half_m1;
  logic [15:0] w_tr_next;
  logic [15:0] w_tc_next;
  logic [15:0] w_tiles_next;
  logic        w_overflow_next;
  logic        w_proto_next;

  assign w_half_m1 = (w_ncols_eff >> 1) - 16'd1;

  always_comb begin
    w_tr_next       = w_tr_eff;
    w_tc_next       = w_tc_eff;
    w_tiles_next    = start ? 16'd0 : r_tiles_done;
    w_overflow_next = (start ? 1'b0 : r_overflow) | w_drop;
    w_proto_next    = (start ? 1'b0 : r_proto_err) | w_multi;
    // Counters advance even when the C22 value itself is dropped.
    if (w_c22_sel) begin
      w_tiles_next = w_tiles_next + 16'd1;
      if (w_tc_eff == w_half_m1) begin
        w_tc_next = 16'd0;
        w_tr_next = w_tr_eff + 16'd1;
      end else begin
        w_tc_next = w_tc_eff + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base       <= '0;
      r_ncols      <= 16'd0;
      r_tr         <= 16'd0;
      r_tc         <= 16'd0;
      r_tiles_done <= 16'd0;
      r_overflow   <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      if (start) begin
        r_base  <= base_addr;
        r_ncols <= n_cols;
      end
      r_tr         <= w_tr_next;
      r_tc         <= w_tc_next;
      r_tiles_done <= w_tiles_next;
      r_overflow   <= w_overflow_next;
      r_proto_err  <= w_proto_next;
    end
  end

  // Reset empties the queue by collapsing the pointers, which also abandons a
  // request that was still waiting for its grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo_addr[w_wr_idx] <= w_addr;
      r_fifo_data[w_wr_idx] <= w_sel_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.  The head entry is held in registers that do not change until the
  // read pointer moves, which only happens on a grant.
  // ---------------------------------------------------------------------------
  assign mem_req    = !w_empty;
  assign busy       = !w_empty;
  assign mem_addr   = w_empty ? '0    : r_fifo_addr[w_rd_idx];
  assign mem_wdata  = w_empty ? 32'd0 : r_fifo_data[w_rd_idx];
  assign mem_we     = 1'b1;
  assign mem_be     = 4'hF;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;
  assign tiles_done = r_tiles_done;

endmodule
